// File: rtl/des_pkg.sv
// Constants, state type and permutation helpers for the DES key schedule.
// Bit 1 is the MSB on every bus, so DES bit n of a [W:1] vector sits at index W+1-n.
package des_pkg;

  localparam int unsigned DES_ROUNDS = 16;
  localparam int unsigned KEY_W      = 64;
  localparam int unsigned HALF_W     = 28;
  localparam int unsigned CD_W       = 56;
  localparam int unsigned SK_W       = 48;
  localparam int unsigned IDX_W      = 5;

  localparam int unsigned PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [SK_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  localparam logic [1:0] SHIFTS [DES_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} ks_state_t;

  // Rotation amount for a 1-based round number (wraps outside 1..16).
  function automatic logic [1:0] shift_of(input logic [IDX_W-1:0] round);
    return SHIFTS[4'(round - 5'd1)];
  endfunction

  function automatic logic [CD_W:1] pc1(input logic [KEY_W:1] k);
    logic [CD_W:1] o;
    for (int i = 1; i <= 56; i++) o[6'(57 - i)] = k[7'(65 - PC1[6'(i - 1)])];
    return o;
  endfunction

  function automatic logic [SK_W:1] pc2(input logic [CD_W:1] cd);
    logic [SK_W:1] o;
    for (int i = 1; i <= 48; i++) o[6'(49 - i)] = cd[6'(57 - PC2[6'(i - 1)])];
    return o;
  endfunction

endpackage

// File: rtl/left_shift.sv
// 28-bit key-half left rotator: rotates by the DES shift count of i_round.
module left_shift
  import des_pkg::*;
(
  input  logic [HALF_W:1]  i_half,
  input  logic [IDX_W-1:0] i_round,
  output logic [HALF_W:1]  o_rot_c
);

  logic [1:0] w_amt;

  assign w_amt   = shift_of(i_round);
  assign o_rot_c = (w_amt == 2'd2) ? {i_half[HALF_W-2:1], i_half[HALF_W:HALF_W-1]}
                                   : {i_half[HALF_W-1:1], i_half[HALF_W]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: one subkey per sk_valid/sk_ready handshake.
// Optional KS_DECRYPT_EN adds a decrypt input that delivers K16 down to K1.
module des_key_schedule
  import des_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W:1]   key,
  output logic [SK_W:1]    sk,
  output logic [IDX_W:1]   sk_idx,
  output logic             sk_valid,
  input  logic             sk_ready,
`ifdef KS_DECRYPT_EN
  input  logic             decrypt,
`endif
  output logic             busy,
  output logic             done
);

  ks_state_t          r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_round, w_round_nxt, w_round_p1;
  logic [HALF_W:1]    r_c, r_d, w_c_nxt, w_d_nxt, w_c_ls, w_d_ls;
  logic [CD_W:1]      w_cd0;
  logic               r_done, w_done_nxt;
`ifdef KS_DECRYPT_EN
  logic               r_dec, w_dec_nxt;
  logic [1:0]         w_rr_amt;
  logic [HALF_W:1]    w_c_rr, w_d_rr;
`endif

  assign w_round_p1 = r_round + 5'd1;
  assign w_cd0      = pc1(key);

  left_shift u_ls_c (.i_half(r_c), .i_round(w_round_p1), .o_rot_c(w_c_ls));
  left_shift u_ls_d (.i_half(r_d), .i_round(w_round_p1), .o_rot_c(w_d_ls));

`ifdef KS_DECRYPT_EN
  // Decrypt walks back from C16/D16, undoing the shift of round 17-r.
  assign w_rr_amt = shift_of(5'd17 - r_round);
  assign w_c_rr   = (w_rr_amt == 2'd2) ? {r_c[2:1], r_c[HALF_W:3]} : {r_c[1], r_c[HALF_W:2]};
  assign w_d_rr   = (w_rr_amt == 2'd2) ? {r_d[2:1], r_d[HALF_W:3]} : {r_d[1], r_d[HALF_W:2]};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_done_nxt  = 1'b0;
`ifdef KS_DECRYPT_EN
    w_dec_nxt   = r_dec;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_c_nxt     = {w_cd0[CD_W-1:HALF_W+1], w_cd0[CD_W]};
          w_d_nxt     = {w_cd0[HALF_W-1:1], w_cd0[HALF_W]};
`ifdef KS_DECRYPT_EN
          w_dec_nxt   = decrypt;
          if (decrypt) begin
            w_c_nxt = w_cd0[CD_W:HALF_W+1];
            w_d_nxt = w_cd0[HALF_W:1];
          end
`endif
          w_round_nxt = 5'd1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sk_valid && sk_ready) begin
          if (r_round == 5'(DES_ROUNDS)) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_round_nxt = w_round_p1;
            w_c_nxt     = w_c_ls;
            w_d_nxt     = w_d_ls;
`ifdef KS_DECRYPT_EN
            if (r_dec) begin
              w_c_nxt = w_c_rr;
              w_d_nxt = w_d_rr;
            end
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_round <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_done  <= 1'b0;
`ifdef KS_DECRYPT_EN
      r_dec   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_done  <= w_done_nxt;
`ifdef KS_DECRYPT_EN
      r_dec   <= w_dec_nxt;
`endif
    end
  end

  assign sk       = pc2({r_c, r_d});
  assign sk_valid = (r_state == ST_RUN);
  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;
`ifdef KS_DECRYPT_EN
  assign sk_idx   = r_dec ? (5'd17 - r_round) : r_round;
`else
  assign sk_idx   = r_round;
`endif

endmodule
